// File: rtl/srambank_req_ctrl_if.sv
// Fabric-side request/response channels of the SRAM bank request controller.
// The master modport is the fabric and the slave modport is the controller.
interface srambank_req_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/srambank_req_ctrl.sv
// In-order request FIFO and issue logic for one synchronous SRAM bank.
// A read is held back while an unconsumed response still owns the bank's dataout.
module srambank_req_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    srambank_req_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] wd,
    output logic              banksel,
    output logic              read,
    output logic              write,
    input  logic [DATA_W-1:0] dataout,
    output logic              idle
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic              fifo_write_r [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_r  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_wdata_r [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             rsp_valid_r;
    logic             rsp_valid_nxt_s;

    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              rsp_free_s;
    logic              head_write_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_wdata_s;
    logic              issue_read_s;
    logic              issue_write_s;

    // Pointers wrap naturally because the depth is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_ONE;
    endfunction

    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full_s     = (count_r == CNT_FULL);
    assign rsp_free_s = !rsp_valid_r || bus.rsp_ready;

    assign head_write_s = fifo_write_r[rd_ptr_r];
    assign head_addr_s  = fifo_addr_r[rd_ptr_r];
    assign head_wdata_s = fifo_wdata_r[rd_ptr_r];

    // Acceptance is held off while reset is asserted and never looks at pop.
    assign bus.req_ready = !full_s && !reset;
    assign push_s        = bus.req_valid && bus.req_ready;
    assign pop_s         = issue_read_s || issue_write_s;

    // Issue decision from the FIFO head; reset aborts any op combinationally.
    always_comb begin
        issue_read_s  = 1'b0;
        issue_write_s = 1'b0;
        if (!empty_s && !reset) begin
            if (head_write_s) begin
                issue_write_s = 1'b1;
            end else if (rsp_free_s) begin
                issue_read_s = 1'b1;
            end else begin
                issue_read_s = 1'b0;
            end
        end else begin
            issue_write_s = 1'b0;
        end
    end

    assign ADDRESS = head_addr_s;
    assign wd      = head_wdata_s;
    assign banksel = issue_read_s || issue_write_s;
    assign read    = issue_read_s;
    assign write   = issue_write_s;

    // Occupancy update for simultaneous push and pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // A read issued in the same cycle as a consume keeps the response valid.
    always_comb begin
        rsp_valid_nxt_s = rsp_valid_r;
        if (issue_read_s) begin
            rsp_valid_nxt_s = 1'b1;
        end else if (bus.rsp_ready) begin
            rsp_valid_nxt_s = 1'b0;
        end else begin
            rsp_valid_nxt_s = rsp_valid_r;
        end
    end

    // FIFO pointers, occupancy and response-valid state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            rsp_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r     <= count_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
        end
    end

    // FIFO entry storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_write_r[i] <= 1'b0;
                fifo_addr_r[i]  <= {ADDR_W{1'b0}};
                fifo_wdata_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_write_r[wr_ptr_r] <= bus.req_write;
            fifo_addr_r[wr_ptr_r]  <= bus.req_addr;
            fifo_wdata_r[wr_ptr_r] <= bus.req_wdata;
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = dataout;
    assign idle          = empty_s && !rsp_valid_r;
endmodule

// File: tb/tb_srambank_req_ctrl.sv
// Directed bench for srambank_req_ctrl with a one-cycle-latency SRAM bank model.
module tb_srambank_req_ctrl;
    localparam logic [63:0] D5 = 64'hDEADBEEF00000005;
    localparam int NV = 23;

    logic        clk;
    logic        reset;
    logic [7:0]  bank_addr;
    logic [63:0] bank_wd;
    logic        bank_sel;
    logic        b_read;
    logic        b_write;
    logic [63:0] dataout;
    logic        idle;
    logic [63:0] mem [256];

    int checks = 0;
    int errors = 0;

    srambank_req_ctrl_if #(.ADDR_W(8), .DATA_W(64)) bus ();

    srambank_req_ctrl #(.ADDR_W(8), .DATA_W(64), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ADDRESS (bank_addr),
        .wd      (bank_wd),
        .banksel (bank_sel),
        .read    (b_read),
        .write   (b_write),
        .dataout (dataout),
        .idle    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank_sel && b_write) mem[bank_addr] <= bank_wd;
        if (bank_sel && b_read)  dataout <= mem[bank_addr];
    end

    typedef struct {
        logic        vld;
        logic        wr;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic        rdy;
        logic        e_rr;
        logic        e_bs;
        logic        e_rd;
        logic        e_wr;
        logic [7:0]  e_addr;
        logic [63:0] e_wd;
        logic        e_rv;
        logic [63:0] e_rdata;
        logic        e_idle;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(logic vld, logic wr, logic [7:0] a, logic [63:0] d, logic rdy,
                                logic rr, logic bs, logic rd, logic ew, logic [7:0] ea,
                                logic [63:0] ed, logic rv, logic [63:0] er, logic idl);
        vec_t v;
        v = '{vld, wr, a, d, rdy, rr, bs, rd, ew, ea, ed, rv, er, idl};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic wr, input logic [7:0] a, input logic [63:0] d);
        bus.req_valid = vld;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic do_read(input string name, input logic [7:0] a, input logic [63:0] exp);
        logic found;
        found = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        drive(1'b1, 1'b0, a, 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 64'd0);
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (bus.rsp_valid) begin
                chk({name, " data"}, bus.rsp_rdata, exp);
                found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk({name, " seen"}, 64'(found), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0]  offer [6];
    logic [63:0] fexp  [5];
    int          accepted;
    int          nrsp;

    initial begin
        // write/read, streaming, then backpressure
        tbl[0]  = mk(1'b1, 1'b1, 8'h05, D5,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b0, 64'd0,  1'b1);
        tbl[1]  = mk(1'b1, 1'b0, 8'h05, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h05, D5,     1'b0, 64'd0,  1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 64'd0,  1'b0, 64'd0,  1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b1, D5,     1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b0, 64'd0,  1'b1);
        tbl[5]  = mk(1'b1, 1'b1, 8'h10, 64'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b0, 64'd0,  1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 8'h11, 64'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 64'h10, 1'b0, 64'd0,  1'b0);
        tbl[7]  = mk(1'b1, 1'b1, 8'h12, 64'h12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 64'h11, 1'b0, 64'd0,  1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 8'h13, 64'h13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 64'h12, 1'b0, 64'd0,  1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 8'h10, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 64'h13, 1'b0, 64'd0,  1'b0);
        tbl[10] = mk(1'b1, 1'b0, 8'h11, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 64'd0,  1'b0, 64'd0,  1'b0);
        tbl[11] = mk(1'b1, 1'b0, 8'h12, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 64'd0,  1'b1, 64'h10, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 8'h13, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 64'd0,  1'b1, 64'h11, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h13, 64'd0,  1'b1, 64'h12, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b1, 64'h13, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b0, 64'd0,  1'b1);
        tbl[16] = mk(1'b1, 1'b0, 8'h10, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b0, 64'd0,  1'b1);
        tbl[17] = mk(1'b1, 1'b0, 8'h11, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 64'd0,  1'b0, 64'd0,  1'b0);
        tbl[18] = mk(1'b1, 1'b1, 8'h10, 64'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b1, 64'h10, 1'b0);
        tbl[19] = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b1, 64'h10, 1'b0);
        tbl[20] = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 64'd0,  1'b1, 64'h10, 1'b0);
        tbl[21] = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 64'hFF, 1'b1, 64'h11, 1'b0);
        tbl[22] = mk(1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0,  1'b0, 64'd0,  1'b1);

        offer[0] = 8'h12; offer[1] = 8'h13; offer[2] = 8'h10;
        offer[3] = 8'h11; offer[4] = 8'h12; offer[5] = 8'h13;
        fexp[0] = 64'h11; fexp[1] = 64'h12; fexp[2] = 64'h13;
        fexp[3] = 64'hFF; fexp[4] = 64'h11;

        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 64'd0);

        // reset held three cycles
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst%0d req_ready", c), 64'(bus.req_ready), 64'd0);
            chk($sformatf("rst%0d rsp_valid", c), 64'(bus.rsp_valid), 64'd0);
            chk($sformatf("rst%0d bank ctl", c), {61'd0, bank_sel, b_read, b_write}, 64'd0);
            chk($sformatf("rst%0d idle", c), 64'(idle), 64'd1);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-rst req_ready", 64'(bus.req_ready), 64'd1);
        chk("post-rst idle", 64'(idle), 64'd1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].vld, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            bus.rsp_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d req_ready", i), 64'(bus.req_ready), 64'(tbl[i].e_rr));
            chk($sformatf("v%0d banksel", i), 64'(bank_sel), 64'(tbl[i].e_bs));
            chk($sformatf("v%0d read", i), 64'(b_read), 64'(tbl[i].e_rd));
            chk($sformatf("v%0d write", i), 64'(b_write), 64'(tbl[i].e_wr));
            chk($sformatf("v%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(tbl[i].e_rv));
            chk($sformatf("v%0d idle", i), 64'(idle), 64'(tbl[i].e_idle));
            if (tbl[i].e_bs) chk($sformatf("v%0d ADDRESS", i), 64'(bank_addr), 64'(tbl[i].e_addr));
            if (tbl[i].e_wr) chk($sformatf("v%0d wd", i), bank_wd, tbl[i].e_wd);
            if (tbl[i].e_rv) chk($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata, tbl[i].e_rdata);
        end

        // full FIFO behind one unconsumed response
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h11, 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 64'd0);
        @(negedge clk);
        #1;
        chk("full pending rsp_valid", 64'(bus.rsp_valid), 64'd1);
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, offer[k], 64'd0);
            #1;
            if (bus.req_ready) accepted++;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 64'd0);
        #1;
        chk("full accepted", 64'(accepted), 64'd4);
        chk("full req_ready", 64'(bus.req_ready), 64'd0);
        chk("full no issue", 64'(bank_sel), 64'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("full ready during pop", 64'(bus.req_ready), 64'd0);
        nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (c == 1) chk("full ready after pop", 64'(bus.req_ready), 64'd1);
            if (bus.rsp_valid && nrsp < 5) begin
                chk($sformatf("full rsp%0d", nrsp), bus.rsp_rdata, fexp[nrsp]);
                nrsp++;
            end
        end
        chk("full rsp count", 64'(nrsp), 64'd5);

        // reset while requests are queued and a response is pending
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h13, 64'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h12, 64'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h12, 64'hAA);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h13, 64'hBB);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 64'd0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("mid pre rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("mid pre read issuing", 64'(b_read), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid bank ctl", {61'd0, bank_sel, b_read, b_write}, 64'd0);
        chk("mid req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid idle", 64'(idle), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("mid quiet%0d banksel", c), 64'(bank_sel), 64'd0);
            @(negedge clk);
        end
        do_read("mid read13", 8'h13, 64'h13);
        do_read("mid read12", 8'h12, 64'h12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
